fetch_responder: RTL and testbench

Synthesizable instruction-memory responder for the fetch port of `seven_stage_core` and its siblings. It drives `fetch_valid`/`fetch_ready`/`fetch_data_in`/`fetch_address_in` in response to the core's `fetch_read`/`fetch_address_out`. Responses come from an internal word array over a fixed-latency read pipeline, and a stall input injects wait states. It replaces hand-driven fetch stimulus in core benches and serves as on-chip boot ROM/RAM in FPGA builds.

---
 rtl/fetch_responder_pkg.sv | 28 ++
 rtl/fetch_responder_ram.sv | 42 ++++
 rtl/fetch_responder.sv | 139 +++++++++++++
 tb/tb_fetch_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_responder_pkg.sv
// Shared definitions for the fetch responder.
//   FETCH_MAX_LATENCY      : deepest supported read pipeline
//   FETCH_MAX_ADDRESS_BITS : widest supported byte address
//   FETCH_MAX_DATA_WIDTH   : widest supported fetch word
//   fetch_stage_t          : one read-pipeline stage {valid, address, data}
//   fetch_word_index()     : byte address -> word index (caller truncates to INDEX_BITS)
package fetch_responder_pkg;

  localparam int unsigned FETCH_MAX_LATENCY      = 4;
  localparam int unsigned FETCH_MAX_ADDRESS_BITS = 64;
  localparam int unsigned FETCH_MAX_DATA_WIDTH   = 64;

  typedef struct packed {
    logic                              valid;
    logic [FETCH_MAX_ADDRESS_BITS-1:0] address;
    logic [FETCH_MAX_DATA_WIDTH-1:0]   data;
  } fetch_stage_t;

  // Drops the byte-offset bits; upper bits are discarded by the caller's
  // truncation, so addresses wrap modulo the array size.
  function automatic logic [FETCH_MAX_ADDRESS_BITS-1:0] fetch_word_index(
    input logic [FETCH_MAX_ADDRESS_BITS-1:0] addr,
    input int unsigned                       offset_bits
  );
    return addr >> offset_bits;
  endfunction

endpackage

// File: rtl/fetch_responder_ram.sv
// Synchronous word array: one read port, one write port, read-before-write.
//   clock    : rising-edge clock
//   rd_clear : clears the read output register (contents untouched)
//   rd_en    : capture mem[rd_index] into rd_data; rd_data holds otherwise
//   rd_index : word index to read
//   rd_data  : registered read data
//   wr_en    : write strobe
//   wr_index : word index to write
//   wr_data  : write data
module fetch_responder_ram #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned INDEX_BITS = 10
) (
  input  logic                  clock,
  input  logic                  rd_clear,
  input  logic                  rd_en,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << INDEX_BITS)-1];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_index] <= wr_data;
    end
  end

  // Separate process keeps the array itself reset-free so it maps to block RAM;
  // a same-edge write is not yet visible here, giving read-before-write.
  always_ff @(posedge clock) begin
    if (rd_clear) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_index];
    end
  end

endmodule

// File: rtl/fetch_responder.sv
// Instruction-memory responder for a core fetch port.
// Parameters: DATA_WIDTH (<= 64), ADDRESS_BITS (<= 64), INDEX_BITS,
//             LATENCY (1..FETCH_MAX_LATENCY).
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   fetch_read          : core request strobe
//   fetch_address_out   : core request byte address
//   stall_in            : freezes the whole responder while high
//   load_en/index/data  : array write port (independent of stall/reset)
//   fetch_ready         : request accepted this cycle if fetch_read is high
//   fetch_valid         : response valid this cycle
//   fetch_data_in       : response word
//   fetch_address_in    : request address echoed with the response
//   outstanding         : accepted, not yet delivered requests
module fetch_responder
  import fetch_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDRESS_BITS = 64,
  parameter int unsigned INDEX_BITS   = 10,
  parameter int unsigned LATENCY      = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fetch_read,
  input  logic [ADDRESS_BITS-1:0] fetch_address_out,
  input  logic                    stall_in,
  input  logic                    load_en,
  input  logic [INDEX_BITS-1:0]   load_index,
  input  logic [DATA_WIDTH-1:0]   load_data,
  output logic                    fetch_ready,
  output logic                    fetch_valid,
  output logic [DATA_WIDTH-1:0]   fetch_data_in,
  output logic [ADDRESS_BITS-1:0] fetch_address_in,
  output logic [2:0]              outstanding
);

  localparam int unsigned OFFSET_BITS = $clog2(DATA_WIDTH / 8);

  logic                    accept;
  logic                    deliver;
  logic [INDEX_BITS-1:0]   rd_index;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    s1_valid;
  logic [ADDRESS_BITS-1:0] s1_address;
  logic [2:0]              count;
  fetch_stage_t            head;
  fetch_stage_t            tail;

  assign fetch_ready = !reset && !stall_in;
  assign accept      = fetch_read && fetch_ready;
  assign rd_index    = INDEX_BITS'(fetch_word_index(
                         FETCH_MAX_ADDRESS_BITS'(fetch_address_out), OFFSET_BITS));

  fetch_responder_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_BITS (INDEX_BITS)
  ) u_ram (
    .clock    (clock),
    .rd_clear (reset),
    .rd_en    (accept),
    .rd_index (rd_index),
    .rd_data  (rd_data),
    .wr_en    (load_en),
    .wr_index (load_index),
    .wr_data  (load_data)
  );

  // Stage 1: valid/address live here, data is the RAM output register.
  // Address only moves on an accept, so it always matches rd_data.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_address <= '0;
    end else if (!stall_in) begin
      s1_valid <= accept;
      if (accept) begin
        s1_address <= fetch_address_out;
      end
    end
  end

  always_comb begin
    head         = '0;
    head.valid   = s1_valid;
    head.address = FETCH_MAX_ADDRESS_BITS'(s1_address);
    head.data    = FETCH_MAX_DATA_WIDTH'(rd_data);
  end

  // Later stages load address/data only behind a valid entry, so the last
  // stage keeps the most recently delivered response when idle.
  if (LATENCY == 1) begin : g_direct
    assign tail = head;
  end else begin : g_pipe
    fetch_stage_t pipe [LATENCY-1];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int unsigned k = 0; k < LATENCY - 1; k++) begin
          pipe[k] <= '0;
        end
      end else if (!stall_in) begin
        pipe[0].valid <= head.valid;
        if (head.valid) begin
          pipe[0].address <= head.address;
          pipe[0].data    <= head.data;
        end
        for (int unsigned k = 1; k < LATENCY - 1; k++) begin
          pipe[k].valid <= pipe[k-1].valid;
          if (pipe[k-1].valid) begin
            pipe[k].address <= pipe[k-1].address;
            pipe[k].data    <= pipe[k-1].data;
          end
        end
      end
    end

    assign tail = pipe[LATENCY-2];
  end

  // A valid last stage under stall is held, not dropped: it is delivered
  // in the first unstalled cycle.
  assign fetch_valid      = tail.valid && !stall_in;
  assign fetch_data_in    = DATA_WIDTH'(tail.data);
  assign fetch_address_in = ADDRESS_BITS'(tail.address);
  assign deliver          = fetch_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (accept && !deliver) begin
      count <= count + 3'd1;
    end else if (deliver && !accept) begin
      count <= count - 3'd1;
    end
  end

  assign outstanding = count;

endmodule

// File: tb/tb_fetch_responder.sv
module tb_fetch_responder;

  localparam int NDUT = 4;  // DUT g has LATENCY g+1, INDEX_BITS 4

  localparam logic [63:0] W0 = 64'h0000_0013_0000_0093;
  localparam logic [63:0] W1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W2 = {32'h0020_0613, 32'h0010_0593};
  localparam logic [63:0] W5 = 64'h5555;
  localparam logic [63:0] WA = 64'hAAAA;

  typedef struct {
    int          dut;
    logic [63:0] addr;
    logic [63:0] data;
    int          acc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_read;
  logic [63:0] fetch_address_out;
  logic        stall_in;
  logic        load_en;
  logic [3:0]  load_index;
  logic [63:0] load_data;

  logic        ready_w [NDUT];
  logic        valid_w [NDUT];
  logic [63:0] data_w  [NDUT];
  logic [63:0] addr_w  [NDUT];
  logic [2:0]  outs_w  [NDUT];

  exp_t q[$];
  int   ns_cnt = 0;
  int   total  = 0;
  int   bad    = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    fetch_responder #(
      .DATA_WIDTH   (64),
      .ADDRESS_BITS (64),
      .INDEX_BITS   (4),
      .LATENCY      (g + 1)
    ) u_dut (
      .clock             (clock),
      .reset             (reset),
      .fetch_read        (fetch_read),
      .fetch_address_out (fetch_address_out),
      .stall_in          (stall_in),
      .load_en           (load_en),
      .load_index        (load_index),
      .load_data         (load_data),
      .fetch_ready       (ready_w[g]),
      .fetch_valid       (valid_w[g]),
      .fetch_data_in     (data_w[g]),
      .fetch_address_in  (addr_w[g]),
      .outstanding       (outs_w[g])
    );
  end

  task automatic chk(input string name, input int g, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h at %0t", name, g, act, exp, $time);
    end
  endtask

  // Counts unstalled edges; an accept stamped A must be delivered while
  // ns_cnt == A + LATENCY - 1. A reset edge flushes all expectations.
  always @(posedge clock) begin
    if (reset) q.delete();
    if (!stall_in) ns_cnt <= ns_cnt + 1;
  end

  always @(negedge clock) begin : mon
    int   idx;
    int   n;
    exp_t e;
    for (int g = 0; g < NDUT; g++) begin
      chk("ready", g, {63'd0, !(reset || stall_in)}, {63'd0, ready_w[g]});
      if (!reset) begin
        if (stall_in) chk("valid_in_stall", g, {63'd0, valid_w[g]}, 64'd0);
        idx = -1;
        n   = 0;
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].dut == g) begin
            if (idx < 0) idx = i;
            if (q[i].acc <= ns_cnt) n++;
          end
        end
        chk("outstanding", g, {61'd0, outs_w[g]}, 64'(n));
        if (valid_w[g] !== 1'b0) begin
          if (idx < 0) begin
            chk("spurious_valid", g, {63'd0, valid_w[g]}, 64'd0);
          end else begin
            e = q[idx];
            q.delete(idx);
            chk("data", g, data_w[g], e.data);
            chk("address", g, addr_w[g], e.addr);
            chk("latency", g, 64'(ns_cnt), 64'(e.acc + g));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    fetch_read = 1'b0;
    load_en    = 1'b0;
    stall_in   = 1'b0;
    repeat (n) tick();
  endtask

  task automatic load(input logic [3:0] idx, input logic [63:0] d);
    load_en    = 1'b1;
    load_index = idx;
    load_data  = d;
    tick();
    load_en = 1'b0;
  endtask

  // Accept happens at the next edge, which is unstalled.
  task automatic req(input logic [63:0] a, input logic [63:0] d);
    exp_t e;
    fetch_read        = 1'b1;
    fetch_address_out = a;
    for (int g = 0; g < NDUT; g++) begin
      e.dut  = g;
      e.addr = a;
      e.data = d;
      e.acc  = ns_cnt + 1;
      q.push_back(e);
    end
    tick();
    fetch_read = 1'b0;
    load_en    = 1'b0;
  endtask

  task automatic chk_reset_state();
    for (int g = 0; g < NDUT; g++) begin
      chk("rst_valid", g, {63'd0, valid_w[g]}, 64'd0);
      chk("rst_data", g, data_w[g], 64'd0);
      chk("rst_address", g, addr_w[g], 64'd0);
      chk("rst_outstanding", g, {61'd0, outs_w[g]}, 64'd0);
    end
  endtask

  initial begin : main
    logic [2:0] peak;
    reset             = 1'b1;
    fetch_read        = 1'b0;
    fetch_address_out = '0;
    stall_in          = 1'b0;
    load_en           = 1'b0;
    load_index        = '0;
    load_data         = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk_reset_state();

    load(4'd0, W0);
    load(4'd1, W1);
    load(4'd2, W2);
    load(4'd5, W5);

    // Same word for both halves; echoed address selects the half.
    req(64'd16, W2);
    idle(5);
    req(64'd20, W2);
    idle(5);

    // Back-to-back, peak occupancy on the LATENCY=3 instance.
    peak = '0;
    req(64'd0, W0);
    if (outs_w[2] > peak) peak = outs_w[2];
    req(64'd8, W1);
    if (outs_w[2] > peak) peak = outs_w[2];
    req(64'd16, W2);
    if (outs_w[2] > peak) peak = outs_w[2];
    for (int i = 0; i < 6; i++) begin
      tick();
      if (outs_w[2] > peak) peak = outs_w[2];
    end
    chk("peak_outstanding", 2, {61'd0, peak}, 64'd3);
    chk("outstanding_end", 2, {61'd0, outs_w[2]}, 64'd0);

    // Stall with a request pending on the port: it must not be accepted.
    req(64'd8, W1);
    stall_in          = 1'b1;
    fetch_read        = 1'b1;
    fetch_address_out = 64'd24;
    repeat (4) tick();
    idle(8);

    // Wrap: 136 >> 3 = 17, modulo 16 -> index 1.
    req(64'd136, W1);
    idle(5);

    // Same-edge load and read of index 5.
    load_en    = 1'b1;
    load_index = 4'd5;
    load_data  = WA;
    req(64'd40, W5);
    req(64'd40, WA);
    idle(6);

    // Reset with requests in flight.
    req(64'd0, W0);
    req(64'd8, W1);
    idle(1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk_reset_state();
    idle(6);
    req(64'd16, W2);
    req(64'd40, WA);

    for (int i = 0; i < 30 && q.size() != 0; i++) tick();
    chk("drain", 0, 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
